// File: rtl/scmp_frame_minmax.sv
// Frame statistics collector: tracks the signed min, max and saturating sample count
// of each input frame and presents one registered summary per frame on a valid/ready port.
module scmp_frame_minmax (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_val,
    output logic       in_rdy,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_val,
    input  logic       out_rdy,
    output logic [7:0] out_min,
    output logic [7:0] out_max,
    output logic [7:0] out_cnt,
    output logic       out_flat
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic signed [7:0] min_q, min_d;
    logic signed [7:0] max_q, max_d;
    logic [7:0]        cnt_q, cnt_d;
    logic signed [7:0] out_min_q, out_min_d;
    logic signed [7:0] out_max_q, out_max_d;
    logic [7:0]        out_cnt_q, out_cnt_d;
    logic              out_flat_q, out_flat_d;

    logic              in_fire;
    logic              out_fire;
    logic signed [7:0] sample;
    logic signed [7:0] upd_min;
    logic signed [7:0] upd_max;
    logic [7:0]        upd_cnt;

    // Count holds at 255 once reached; min/max keep tracking beyond that point.
    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    always_comb begin
        sample   = $signed(in_data);
        in_fire  = (state_q == ACCUM) && in_val;
        out_fire = (state_q == HOLD) && out_rdy;

        if (cnt_q == 8'd0) begin
            upd_min = sample;
            upd_max = sample;
            upd_cnt = 8'd1;
        end else begin
            upd_min = (sample < min_q) ? sample : min_q;
            upd_max = (sample > max_q) ? sample : max_q;
            upd_cnt = sat_inc(cnt_q);
        end

        state_d    = state_q;
        min_d      = min_q;
        max_d      = max_q;
        cnt_d      = cnt_q;
        out_min_d  = out_min_q;
        out_max_d  = out_max_q;
        out_cnt_d  = out_cnt_q;
        out_flat_d = out_flat_q;

        if (in_fire) begin
            min_d = upd_min;
            max_d = upd_max;
            cnt_d = upd_cnt;
            // The summary captures the updated values so the last sample is included.
            if (in_last) begin
                state_d    = HOLD;
                out_min_d  = upd_min;
                out_max_d  = upd_max;
                out_cnt_d  = upd_cnt;
                out_flat_d = (upd_min == upd_max);
            end
        end

        if (out_fire) begin
            state_d = ACCUM;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ACCUM;
            min_q      <= 8'sd0;
            max_q      <= 8'sd0;
            cnt_q      <= 8'd0;
            out_min_q  <= 8'sd0;
            out_max_q  <= 8'sd0;
            out_cnt_q  <= 8'd0;
            out_flat_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            min_q      <= min_d;
            max_q      <= max_d;
            cnt_q      <= cnt_d;
            out_min_q  <= out_min_d;
            out_max_q  <= out_max_d;
            out_cnt_q  <= out_cnt_d;
            out_flat_q <= out_flat_d;
        end
    end

    // Handshake flags come from state alone so neither port sees a combinational path.
    assign in_rdy   = (state_q == ACCUM);
    assign out_val  = (state_q == HOLD);
    assign out_min  = out_min_q;
    assign out_max  = out_max_q;
    assign out_cnt  = out_cnt_q;
    assign out_flat = out_flat_q;

endmodule

// File: tb/tb_scmp_frame_minmax.sv
// Directed bench for scmp_frame_minmax: one task per scenario, inline comparisons.
module tb_scmp_frame_minmax;

    logic       clk;
    logic       reset_n;
    logic       in_val;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_val;
    logic       out_rdy;
    logic [7:0] out_min;
    logic [7:0] out_max;
    logic [7:0] out_cnt;
    logic       out_flat;

    int checks = 0;
    int errors = 0;

    logic [7:0] b2b_data [16] = '{8'h03, 8'hFB, 8'h0A, 8'h00, 8'h7F, 8'h80, 8'h07, 8'h07,
                                  8'h07, 8'h07, 8'h07, 8'hFF, 8'h10, 8'hF0, 8'h10, 8'h01};
    bit         b2b_last [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    scmp_frame_minmax dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_min  (out_min),
        .out_max  (out_max),
        .out_cnt  (out_cnt),
        .out_flat (out_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic push(input logic [7:0] d, input logic l);
        int n;
        in_val  = 1'b1;
        in_data = d;
        in_last = l;
        n = 0;
        while (!in_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_rdy stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        in_val  = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        in_val  = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out_rdy = 1'b0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        checks++; if (out_min !== 8'h00) begin errors++; $display("FAIL reset_out_min: got %h want 00", out_min); end
        checks++; if (out_max !== 8'h00) begin errors++; $display("FAIL reset_out_max: got %h want 00", out_max); end
        checks++; if (out_cnt !== 8'h00) begin errors++; $display("FAIL reset_out_cnt: got %h want 00", out_cnt); end
        checks++; if (out_flat !== 1'b0) begin errors++; $display("FAIL reset_out_flat: got %b want 0", out_flat); end
        reset_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        out_rdy = 1'b1;
        push(8'h05, 1'b0);
        push(8'hFD, 1'b0);
        push(8'h07, 1'b1);
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL basic_out_val: got %b want 1", out_val); end
        checks++; if (out_min !== 8'hFD) begin errors++; $display("FAIL basic_min: got %h want fd", out_min); end
        checks++; if (out_max !== 8'h07) begin errors++; $display("FAIL basic_max: got %h want 07", out_max); end
        checks++; if (out_cnt !== 8'd3) begin errors++; $display("FAIL basic_cnt: got %0d want 3", out_cnt); end
        checks++; if (out_flat !== 1'b0) begin errors++; $display("FAIL basic_flat: got %b want 0", out_flat); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL basic_in_rdy_hold: got %b want 0", in_rdy); end
        @(negedge clk);
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL basic_out_val_after: got %b want 0", out_val); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL basic_in_rdy_after: got %b want 1", in_rdy); end
        out_rdy = 1'b0;
    endtask

    task automatic test_signed_extremes();
        push(8'h80, 1'b0);
        push(8'h7F, 1'b1);
        checks++; if (out_min !== 8'h80) begin errors++; $display("FAIL signed_min: got %h want 80", out_min); end
        checks++; if (out_max !== 8'h7F) begin errors++; $display("FAIL signed_max: got %h want 7f", out_max); end
        checks++; if (out_cnt !== 8'd2) begin errors++; $display("FAIL signed_cnt: got %0d want 2", out_cnt); end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic test_single_hold();
        push(8'h00, 1'b1);
        for (int c = 0; c < 4; c++) begin
            // Junk on the input side must be ignored while the summary is pending.
            in_val  = 1'b1;
            in_data = 8'h55 + 8'(c);
            in_last = 1'b1;
            checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL hold_out_val c%0d: got %b want 1", c, out_val); end
            checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL hold_in_rdy c%0d: got %b want 0", c, in_rdy); end
            checks++;
            if (out_min !== 8'h00 || out_max !== 8'h00 || out_cnt !== 8'd1 || out_flat !== 1'b1) begin
                errors++;
                $display("FAIL hold_summary c%0d: got min %h max %h cnt %0d flat %b want 00 00 1 1",
                         c, out_min, out_max, out_cnt, out_flat);
            end
            @(negedge clk);
        end
        in_val  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b1;
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL hold_out_val_rise: got %b want 1", out_val); end
        @(negedge clk);
        out_rdy = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL hold_out_val_done: got %b want 0", out_val); end
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL hold_in_rdy_done: got %b want 1", in_rdy); end
    endtask

    task automatic test_last_ignored();
        in_val  = 1'b0;
        in_last = 1'b1;
        in_data = 8'h99;
        @(negedge clk);
        in_last = 1'b0;
        checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL ignore_last_out_val: got %b want 0", out_val); end
        push(8'h02, 1'b0);
        push(8'h06, 1'b1);
        checks++;
        if (out_min !== 8'h02 || out_max !== 8'h06 || out_cnt !== 8'd2) begin
            errors++;
            $display("FAIL ignore_last_summary: got min %h max %h cnt %0d want 02 06 2", out_min, out_max, out_cnt);
        end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic test_long_frame();
        for (int i = 1; i <= 300; i++) begin
            push((i == 280) ? 8'hF0 : 8'h11, (i == 300));
        end
        checks++; if (out_val !== 1'b1) begin errors++; $display("FAIL long_out_val: got %b want 1", out_val); end
        checks++; if (out_cnt !== 8'd255) begin errors++; $display("FAIL long_cnt: got %0d want 255", out_cnt); end
        checks++; if (out_min !== 8'hF0) begin errors++; $display("FAIL long_min: got %h want f0", out_min); end
        checks++; if (out_max !== 8'h11) begin errors++; $display("FAIL long_max: got %h want 11", out_max); end
        out_rdy = 1'b1;
        @(negedge clk);
        out_rdy = 1'b0;
    endtask

    task automatic test_reset_midframe();
        push(8'h64, 1'b0);
        push(8'h9C, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1 || out_val !== 1'b0) begin errors++; $display("FAIL midreset_async: got in_rdy %b out_val %b want 1 0", in_rdy, out_val); end
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b1;
        push(8'h04, 1'b1);
        checks++;
        if (out_val !== 1'b1 || out_min !== 8'h04 || out_max !== 8'h04 || out_cnt !== 8'd1 || out_flat !== 1'b1) begin
            errors++;
            $display("FAIL midreset_summary: got val %b min %h max %h cnt %0d flat %b want 1 04 04 1 1",
                     out_val, out_min, out_max, out_cnt, out_flat);
        end
        @(negedge clk);
        out_rdy = 1'b0;
        // A pending summary is dropped by reset too.
        push(8'h09, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (out_val !== 1'b0) begin errors++; $display("FAIL holdreset_out_val c%0d: got %b want 0", c, out_val); end
            @(negedge clk);
        end
        out_rdy = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic signed [7:0] m_min, m_max;
        logic [7:0]        m_cnt;
        logic [7:0]        e_min [8];
        logic [7:0]        e_max [8];
        logic [7:0]        e_cnt [8];
        int idx, fr, nexp, cyc;
        idx = 0; fr = 0; nexp = 0; cyc = 0;
        m_min = 0; m_max = 0; m_cnt = 0;
        while (cyc < 500 && fr < 6) begin
            in_val = (idx < 16);
            if (idx < 16) begin
                in_data = b2b_data[idx];
                in_last = b2b_last[idx];
            end
            out_rdy = 1'($urandom_range(0, 1));
            if (out_val && out_rdy) begin
                checks++;
                if (fr >= nexp || out_min !== e_min[fr] || out_max !== e_max[fr] || out_cnt !== e_cnt[fr] ||
                    out_flat !== (e_min[fr] == e_max[fr])) begin
                    errors++;
                    $display("FAIL b2b_frame%0d: got min %h max %h cnt %0d flat %b want %h %h %0d",
                             fr, out_min, out_max, out_cnt, out_flat, e_min[fr], e_max[fr], e_cnt[fr]);
                end
                fr++;
            end
            if (in_val && in_rdy) begin
                if (m_cnt == 0) begin
                    m_min = $signed(in_data);
                    m_max = $signed(in_data);
                    m_cnt = 1;
                end else begin
                    if ($signed(in_data) < m_min) m_min = $signed(in_data);
                    if ($signed(in_data) > m_max) m_max = $signed(in_data);
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 1;
                end
                if (in_last) begin
                    e_min[nexp] = m_min;
                    e_max[nexp] = m_max;
                    e_cnt[nexp] = m_cnt;
                    nexp++;
                    m_cnt = 0;
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        in_val  = 1'b0;
        in_last = 1'b0;
        out_rdy = 1'b0;
        checks++; if (fr != 6) begin errors++; $display("FAIL b2b_frames_seen: got %0d want 6", fr); end
        checks++; if (idx != 16) begin errors++; $display("FAIL b2b_samples_taken: got %0d want 16", idx); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_signed_extremes();
        test_single_hold();
        test_last_ignored();
        test_long_frame();
        test_reset_midframe();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scmp_frame_minmax.md
SCMP_FRAME_MINMAX -- requirements
Module: scmp_frame_minmax

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 8 bits, two's-complement signed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_val  input  1  upstream sample valid.
REQ-005 in_rdy  output  1  block can accept a sample this cycle.
REQ-006 in_data  input  8  signed sample.
REQ-007 in_last  input  1  sample is the last of its frame; qualified by in_val & in_rdy.
REQ-008 out_val  output  1  frame summary valid.
REQ-009 out_rdy  input  1  downstream accepts summary.
REQ-010 out_min  output  8  signed minimum of the frame.
REQ-011 out_max  output  8  signed maximum of the frame.
REQ-012 out_cnt  output  8  samples in frame, saturating at 255.
REQ-013 out_flat  output  1  1 when out_min == out_max.

Function
REQ-014 An input transfer SHALL occur exactly on a cycle with in_val & in_rdy both high; an output transfer exactly on a cycle with out_val & out_rdy both high.
REQ-015 The FSM SHALL have two states: ACCUM (in_rdy=1, out_val=0) and HOLD (in_rdy=0, out_val=1); in_rdy and out_val are decoded from state only, never from in_val or out_rdy.
REQ-016 ACCUM -> HOLD on an input transfer with in_last=1; HOLD -> ACCUM on an output transfer; otherwise the state is unchanged.
REQ-017 The first transfer of a frame (cnt==0) SHALL load min=max=in_data and cnt=1.
REQ-018 Each later transfer SHALL set min=in_data if $signed(in_data) < $signed(min), max=in_data if $signed(in_data) > $signed(max), else keep them; equal values SHALL update neither.
REQ-019 Each later transfer SHALL increment cnt by 1, saturating at 255 (the 256th and later samples leave cnt at 255 while min/max continue updating).
REQ-020 Comparisons SHALL be signed: 8'h80 (-128) is the smallest and 8'h7F (+127) the largest value.
REQ-021 A single-sample frame (in_last on the first transfer) SHALL yield min=max=sample, cnt=1, out_flat=1.
REQ-022 out_val SHALL rise in the cycle after the in_last transfer (latency 1); summary outputs SHALL be registered and include the last sample.
REQ-023 In HOLD, out_min/out_max/out_cnt/out_flat SHALL remain stable until the output transfer, regardless of in_val/in_data.
REQ-024 On the output transfer, cnt SHALL clear to 0; the next frame may be accepted in the following cycle (one bubble per frame, no input accepted in HOLD).
REQ-025 Outputs out_min/out_max/out_cnt/out_flat while in ACCUM SHALL hold the last delivered summary (don't-care for checking except after reset).
REQ-026 in_last on a non-transfer cycle SHALL be ignored.

Reset
REQ-027 reset_n low SHALL immediately force state=ACCUM, cnt=0, out_min=0, out_max=0, out_cnt=0, out_flat=0, out_val=0, in_rdy=1.
REQ-028 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending summary; no output transfer for it occurs after deassertion.
REQ-029 First input transfer SHALL be possible on the first rising edge after reset_n deasserts.

Verification
REQ-030 Frame 5, -3, 7(last), out_rdy=1 -> out_val one cycle after last; out_min=8'hFD, out_max=8'h07, out_cnt=3, out_flat=0.
REQ-031 Frame 8'h80, 8'h7F(last) -> out_min=8'h80, out_max=8'h7F (signed, not unsigned ordering).
REQ-032 Single sample 8'h00 with in_last, out_rdy held low 4 cycles -> out_val=1 and outputs stable (min=max=0, cnt=1, flat=1), in_rdy=0 throughout; transfer on cycle out_rdy rises, in_rdy=1 the next cycle.
REQ-033 300-sample frame of value 8'h11 except sample 280 = 8'hF0 -> out_cnt=255, out_min=8'hF0, out_max=8'h11.
REQ-034 reset_n pulsed low after 2 samples of a frame, then frame 4(last) -> summary min=max=4, cnt=1; no stale summary emitted.
REQ-035 Back-to-back frames with in_val held high and random out_rdy -> every frame summary matches a software signed min/max/count model, no sample lost or duplicated.
